// File: rtl/data_sram_bridge.sv
// Bridges the core's single-cycle M-stage data port onto an SRAM-like addr_ok/data_ok bus,
// stalling the pipeline while an access is outstanding, with flush handling and a timeout watchdog.
module data_sram_bridge #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memenM,
   input  logic [3:0]  memwriteM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   input  logic        flushM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic        discard;
   logic        access;
   logic        discard_eff;
   logic        timeout_hit;

   assign access      = (memenM | (|memwriteM)) & ~flushM;
   assign discard_eff = discard | flushM;
   assign timeout_hit = (cnt == TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stallM    = 1'b0;
      bus_req   = 1'b0;
      case (state)
         S_IDLE: begin
            stallM = access;
            if (access) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            bus_req = 1'b1;
            stallM  = 1'b1;
            if (bus_addr_ok) begin
               if (bus_data_ok) begin
                  state_nxt = flushM ? S_IDLE : S_DONE;
               end else begin
                  state_nxt = S_WAIT;
               end
            end else if (flushM) begin
               // Request never accepted, so it can be withdrawn outright.
               stallM    = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            stallM = 1'b1;
            if (bus_data_ok || timeout_hit) begin
               state_nxt = discard_eff ? S_IDLE : S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         readdataM <= '0;
         bus_wr    <= 1'b0;
         bus_wstrb <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_err   <= 1'b0;
         cnt       <= '0;
         discard   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (access) begin
                  bus_addr  <= aluoutM & ~32'h3;
                  bus_wdata <= writedataM;
                  bus_wr    <= |memwriteM;
                  bus_wstrb <= memwriteM;
                  discard   <= 1'b0;
               end
            end
            S_REQ: begin
               if (bus_addr_ok) begin
                  cnt     <= '0;
                  discard <= flushM;
                  if (bus_data_ok && !bus_wr && !flushM) begin
                     readdataM <= bus_rdata;
                  end
               end
            end
            S_WAIT: begin
               cnt <= cnt + 16'd1;
               if (flushM) begin
                  discard <= 1'b1;
               end
               if (bus_data_ok) begin
                  if (!bus_wr && !discard_eff) begin
                     readdataM <= bus_rdata;
                  end
               end else if (timeout_hit) begin
                  // Sticky until reset; a late data_ok lands outside WAIT and is dropped.
                  bus_err <= 1'b1;
                  if (!bus_wr && !discard_eff) begin
                     readdataM <= ERR_DATA;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: per-scenario tasks with a queue of expected
// load results pushed at issue and popped when the bridge reports completion.
module tb_data_sram_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memenM = 1'b0;
   logic [3:0]  memwriteM = '0;
   logic [31:0] aluoutM = '0;
   logic [31:0] writedataM = '0;
   logic        flushM = 1'b0;
   logic [31:0] readdataM;
   logic        stallM;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok = 1'b0;
   logic        bus_data_ok = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        bus_err;

   int          total = 0;
   int          bad = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_rd;
   int          stalls;

   always #5 clk = ~clk;

   data_sram_bridge #(
      .TIMEOUT (8),
      .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .memenM     (memenM),
      .memwriteM  (memwriteM),
      .aluoutM    (aluoutM),
      .writedataM (writedataM),
      .flushM     (flushM),
      .readdataM  (readdataM),
      .stallM     (stallM),
      .bus_req    (bus_req),
      .bus_wr     (bus_wr),
      .bus_wstrb  (bus_wstrb),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok),
      .bus_rdata  (bus_rdata),
      .bus_err    (bus_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #2;
      total++;
      if (readdataM !== 32'h0) begin
         bad++;
         $display("FAIL reset_readdata got=%h exp=%h", readdataM, 32'h0);
      end
      total++;
      if ({stallM, bus_req, bus_wr, bus_wstrb, bus_err} !== 8'h00) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=%b", {stallM, bus_req, bus_wr, bus_wstrb, bus_err}, 8'h00);
      end
      total++;
      if ({bus_addr, bus_wdata} !== 64'h0) begin
         bad++;
         $display("FAIL reset_bus got=%h exp=%h", {bus_addr, bus_wdata}, 64'h0);
      end
   endtask

   task automatic test_load_zero_wait();
      memenM  = 1'b1;
      aluoutM = 32'h1000_0006;
      sb.push_back(32'h1234_5678);
      #2;
      total++;
      if (stallM !== 1'b1) begin
         bad++;
         $display("FAIL load_stall_t got=%b exp=1", stallM);
      end
      tick();
      bus_addr_ok = 1'b1;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'h1234_5678;
      #2;
      total++;
      if ({bus_req, stallM, bus_wr, bus_wstrb} !== 7'b1100000) begin
         bad++;
         $display("FAIL load_req_ctrl got=%b exp=%b", {bus_req, stallM, bus_wr, bus_wstrb}, 7'b1100000);
      end
      total++;
      if (bus_addr !== 32'h1000_0004) begin
         bad++;
         $display("FAIL load_addr got=%h exp=%h", bus_addr, 32'h1000_0004);
      end
      tick();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      #2;
      total++;
      if ({stallM, bus_req} !== 2'b00) begin
         bad++;
         $display("FAIL load_done_ctrl got=%b exp=00", {stallM, bus_req});
      end
      exp_rd = sb.pop_front();
      total++;
      if (readdataM !== exp_rd) begin
         bad++;
         $display("FAIL load_rdata got=%h exp=%h", readdataM, exp_rd);
      end
      tick();
      memenM = 1'b0;
   endtask

   task automatic test_store_delayed();
      memwriteM  = 4'b0011;
      aluoutM    = 32'h2000_0008;
      writedataM = 32'h0000_ABCD;
      sb.push_back(32'h1234_5678);
      stalls = 0;
      #2;
      if (stallM === 1'b1) stalls++;
      tick();
      for (int i = 0; i < 4; i++) begin
         bus_addr_ok = (i == 3);
         #2;
         total++;
         if ({bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata} !==
             {1'b1, 1'b1, 4'b0011, 32'h2000_0008, 32'h0000_ABCD}) begin
            bad++;
            $display("FAIL store_req_fields[%0d] got=%h exp=%h", i,
                     {bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata},
                     {1'b1, 1'b1, 4'b0011, 32'h2000_0008, 32'h0000_ABCD});
         end
         if (stallM === 1'b1) stalls++;
         tick();
      end
      bus_addr_ok = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus_data_ok = (i == 1);
         #2;
         total++;
         if (bus_req !== 1'b0) begin
            bad++;
            $display("FAIL store_wait_req[%0d] got=%b exp=0", i, bus_req);
         end
         if (stallM === 1'b1) stalls++;
         tick();
      end
      bus_data_ok = 1'b0;
      #2;
      total++;
      if (stallM !== 1'b0) begin
         bad++;
         $display("FAIL store_done_stall got=%b exp=0", stallM);
      end
      total++;
      if (stalls != 7) begin
         bad++;
         $display("FAIL store_stall_count got=%0d exp=7", stalls);
      end
      exp_rd = sb.pop_front();
      total++;
      if (readdataM !== exp_rd) begin
         bad++;
         $display("FAIL store_rdata_kept got=%h exp=%h", readdataM, exp_rd);
      end
      tick();
      memwriteM  = '0;
      writedataM = '0;
   endtask

   task automatic test_flush_req();
      memenM  = 1'b1;
      aluoutM = 32'h3000_0000;
      #2;
      tick();
      flushM = 1'b1;
      #2;
      total++;
      if ({bus_req, stallM} !== 2'b10) begin
         bad++;
         $display("FAIL flush_req_cycle got=%b exp=10", {bus_req, stallM});
      end
      tick();
      flushM = 1'b0;
      memenM = 1'b0;
      #2;
      total++;
      if ({bus_req, stallM} !== 2'b00) begin
         bad++;
         $display("FAIL flush_req_after got=%b exp=00", {bus_req, stallM});
      end
      tick();
      #2;
      total++;
      if (readdataM !== 32'h1234_5678 || bus_req !== 1'b0) begin
         bad++;
         $display("FAIL flush_req_quiet got=%h/%b exp=%h/0", readdataM, bus_req, 32'h1234_5678);
      end
   endtask

   task automatic test_flush_wait();
      memenM  = 1'b1;
      aluoutM = 32'h4000_0000;
      #2;
      tick();
      bus_addr_ok = 1'b1;
      #2;
      tick();
      bus_addr_ok = 1'b0;
      memenM      = 1'b0;
      for (int i = 0; i < 5; i++) begin
         flushM      = (i == 0);
         bus_data_ok = (i == 4);
         bus_rdata   = (i == 4) ? 32'hFFFF_0000 : 32'h0;
         #2;
         total++;
         if (stallM !== 1'b1) begin
            bad++;
            $display("FAIL flush_wait_stall[%0d] got=%b exp=1", i, stallM);
         end
         tick();
      end
      flushM      = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      // A new load here stalls at once only if the bridge went straight back to idle.
      memenM  = 1'b1;
      aluoutM = 32'h4000_0010;
      sb.push_back(32'h55AA_55AA);
      #2;
      total++;
      if (stallM !== 1'b1) begin
         bad++;
         $display("FAIL flush_wait_no_done got=%b exp=1", stallM);
      end
      total++;
      if (readdataM !== 32'h1234_5678) begin
         bad++;
         $display("FAIL flush_wait_rdata got=%h exp=%h", readdataM, 32'h1234_5678);
      end
      tick();
      bus_addr_ok = 1'b1;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'h55AA_55AA;
      #2;
      tick();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      #2;
      exp_rd = sb.pop_front();
      total++;
      if (readdataM !== exp_rd || stallM !== 1'b0) begin
         bad++;
         $display("FAIL flush_wait_next got=%h/%b exp=%h/0", readdataM, stallM, exp_rd);
      end
      tick();
      memenM = 1'b0;
   endtask

   task automatic test_timeout();
      memenM  = 1'b1;
      aluoutM = 32'h5000_0010;
      #2;
      tick();
      bus_addr_ok = 1'b1;
      #2;
      tick();
      bus_addr_ok = 1'b0;
      sb.push_back(32'hDEAD_BEEF);
      for (int i = 0; i < 8; i++) begin
         #2;
         total++;
         if ({stallM, bus_err} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_wait[%0d] got=%b exp=10", i, {stallM, bus_err});
         end
         tick();
      end
      #2;
      total++;
      if ({bus_err, stallM} !== 2'b10) begin
         bad++;
         $display("FAIL timeout_done got=%b exp=10", {bus_err, stallM});
      end
      exp_rd = sb.pop_front();
      total++;
      if (readdataM !== exp_rd) begin
         bad++;
         $display("FAIL timeout_rdata got=%h exp=%h", readdataM, exp_rd);
      end
      tick();
      memenM      = 1'b0;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'h1111_1111;
      #2;
      tick();
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      #2;
      total++;
      if (readdataM !== 32'hDEAD_BEEF || stallM !== 1'b0) begin
         bad++;
         $display("FAIL late_data_ok got=%h/%b exp=%h/0", readdataM, stallM, 32'hDEAD_BEEF);
      end
      memenM  = 1'b1;
      aluoutM = 32'h5000_0020;
      sb.push_back(32'h0BAD_F00D);
      #2;
      tick();
      bus_addr_ok = 1'b1;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'h0BAD_F00D;
      #2;
      tick();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      #2;
      exp_rd = sb.pop_front();
      total++;
      if (readdataM !== exp_rd) begin
         bad++;
         $display("FAIL post_timeout_rdata got=%h exp=%h", readdataM, exp_rd);
      end
      total++;
      if (bus_err !== 1'b1) begin
         bad++;
         $display("FAIL bus_err_sticky got=%b exp=1", bus_err);
      end
      tick();
      memenM = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         memenM  = 1'b1;
         aluoutM = 32'h7000_0000 + 32'(4 * k) + 32'(k);
         sb.push_back(32'hA5A5_0000 | 32'(k));
         #2;
         tick();
         bus_addr_ok = 1'b1;
         bus_data_ok = 1'b1;
         bus_rdata   = 32'hA5A5_0000 | 32'(k);
         #2;
         total++;
         if (bus_addr !== 32'h7000_0000 + 32'(4 * k)) begin
            bad++;
            $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, bus_addr, 32'h7000_0000 + 32'(4 * k));
         end
         tick();
         bus_addr_ok = 1'b0;
         bus_data_ok = 1'b0;
         bus_rdata   = '0;
         #2;
         exp_rd = sb.pop_front();
         total++;
         if (readdataM !== exp_rd || stallM !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done[%0d] got=%h/%b exp=%h/0", k, readdataM, stallM, exp_rd);
         end
         tick();
      end
      memenM = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      memenM  = 1'b1;
      aluoutM = 32'h6000_0004;
      #2;
      tick();
      bus_addr_ok = 1'b1;
      #2;
      tick();
      bus_addr_ok = 1'b0;
      memenM      = 1'b0;
      #2;
      tick();
      rst = 1'b0;
      #2;
      tick();
      rst = 1'b1;
      #2;
      total++;
      if ({readdataM, bus_addr, bus_wdata} !== 96'h0) begin
         bad++;
         $display("FAIL midreset_data got=%h exp=0", {readdataM, bus_addr, bus_wdata});
      end
      total++;
      if ({stallM, bus_req, bus_wr, bus_wstrb, bus_err} !== 8'h00) begin
         bad++;
         $display("FAIL midreset_ctrl got=%b exp=%b", {stallM, bus_req, bus_wr, bus_wstrb, bus_err}, 8'h00);
      end
      bus_data_ok = 1'b1;
      bus_rdata   = 32'h7777_7777;
      #2;
      tick();
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      #2;
      total++;
      if (readdataM !== 32'h0 || {stallM, bus_req} !== 2'b00) begin
         bad++;
         $display("FAIL midreset_stray got=%h/%b exp=0/00", readdataM, {stallM, bus_req});
      end
   endtask

   initial begin
      test_reset();
      test_load_zero_wait();
      test_store_delayed();
      test_flush_req();
      test_flush_wait();
      test_timeout();
      test_back_to_back();
      test_reset_mid_wait();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
